// File: rtl/spi_flash_arbiter_if.sv
// Bundle of requester-side and flash-pin signals for the two-way SPI flash arbiter.
// Latency: none (wires only).
// Backpressure: req/grant handshake; a requester waits for its grant before driving the bus.
interface spi_flash_arbiter_if;
  logic [1:0] req;
  logic [1:0] grant;
  logic [1:0] m_cs_b;
  logic [1:0] m_sck;
  logic [1:0] m_mosi;
  logic [1:0] m_miso;
  logic       spi_cs;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;
  logic       busy;
  logic       timeout_evt;

  // Arbiter side
  modport slave (
    input  req, m_cs_b, m_sck, m_mosi, spi_miso,
    output grant, m_miso, spi_cs, spi_sck, spi_mosi, busy, timeout_evt
  );

  // Requester / pin side
  modport master (
    output req, m_cs_b, m_sck, m_mosi, spi_miso,
    input  grant, m_miso, spi_cs, spi_sck, spi_mosi, busy, timeout_evt
  );
endinterface

// File: rtl/spi_flash_arbiter.sv
// Round-robin owner of one SPI flash between two masters, with CS-high gap and idle revocation.
// Latency: grant one edge after req is sampled; pins are a combinational mux of the owner.
// Backpressure: non-owners are held off (no grant) until release/revocation plus CS_GAP cycles.
module spi_flash_arbiter #(
  parameter int CS_GAP   = 4,
  parameter int MAX_HOLD = 1000000
) (
  input  logic               clk,
  input  logic               reset,
  spi_flash_arbiter_if.slave bus
);

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int GW = (CS_GAP > 0) ? $clog2(CS_GAP + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [GW-1:0] GAP_LAST  = GW'((CS_GAP > 0) ? CS_GAP - 1 : 0);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, GAP = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          last_q, last_d;      // most recent winner; also the owner while in OWN
  logic [1:0]    mask_q, mask_d;      // requesters revoked and not yet re-armed by dropping req
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          timeout_evt_q, timeout_evt_d;
  logic          busy_q, busy_d;

  logic [1:0]    eligible;
  logic          winner;
  logic          owner_cs_b;

  assign owner_cs_b = bus.m_cs_b[last_q];

  // State register: all flops, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= 2'b00;
      last_q        <= 1'b1;
      mask_q        <= 2'b00;
      hold_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      timeout_evt_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      mask_q        <= mask_d;
      hold_cnt_q    <= hold_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      timeout_evt_q <= timeout_evt_d;
      busy_q        <= busy_d;
    end
  end

  // Next state: arbitration in IDLE, release/revocation in OWN, guard countdown in GAP
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    mask_d        = mask_q & bus.req;   // dropping req re-arms a revoked requester
    hold_cnt_d    = hold_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    timeout_evt_d = 1'b0;
    eligible      = bus.req & ~mask_q;
    winner        = last_q;
    case (state_q)
      IDLE: begin
        if (eligible != 2'b00) begin
          // On a tie the requester that did not win last time goes first
          winner     = (eligible == 2'b11) ? ~last_q : eligible[1];
          grant_d    = winner ? 2'b10 : 2'b01;
          last_d     = winner;
          state_d    = OWN;
          hold_cnt_d = '0;
        end
      end
      OWN: begin
        if (!bus.req[last_q]) begin
          // Voluntary release takes priority over a coincident hold expiry
          grant_d   = 2'b00;
          state_d   = (CS_GAP > 0) ? GAP : IDLE;
          gap_cnt_d = '0;
        end else if ((MAX_HOLD > 0) && owner_cs_b && (hold_cnt_q == HOLD_LAST)) begin
          grant_d         = 2'b00;
          mask_d[last_q]  = 1'b1;
          timeout_evt_d   = 1'b1;
          state_d         = (CS_GAP > 0) ? GAP : IDLE;
          gap_cnt_d       = '0;
        end else if (owner_cs_b) begin
          if (hold_cnt_q != '1) hold_cnt_d = hold_cnt_q + HW'(1);
        end else begin
          hold_cnt_d = '0;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = IDLE;
        else                       gap_cnt_d = gap_cnt_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Outputs: pins follow the owner only in OWN, otherwise (and under reset) sit deselected
  always_comb begin
    bus.spi_cs   = 1'b1;
    bus.spi_sck  = 1'b0;
    bus.spi_mosi = 1'b0;
    if (!reset && (state_q == OWN)) begin
      bus.spi_cs   = bus.m_cs_b[last_q];
      bus.spi_sck  = bus.m_sck[last_q];
      bus.spi_mosi = bus.m_mosi[last_q];
    end
    bus.m_miso = {2{bus.spi_miso}};
  end

  assign bus.grant       = grant_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_evt = timeout_evt_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Scoreboard bench for spi_flash_arbiter: grant/timeout events queued by a reference model.
// Latency: model events are expected at the negedge right after the edge that causes them.
// Backpressure: stimulus reacts to grants; all waits are cycle-bounded.
module tb_spi_flash_arbiter;

  localparam int CS_GAP   = 4;
  localparam int MAX_HOLD = 8;

  logic clk;
  logic reset;
  spi_flash_arbiter_if bus ();

  spi_flash_arbiter #(.CS_GAP(CS_GAP), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0] g;
    logic       to;
    int         cyc;
  } ev_t;
  ev_t exp_q[$];

  bit         mo_has  = 1'b0;  // someone owns the flash
  logic       mo_who  = 1'b0;  // which one
  int         mo_cool = 0;     // guard cycles still to run before arbitration resumes
  int         mo_run  = 0;     // consecutive sampled cycles the owner kept cs_b high
  logic       mo_last = 1'b1;
  logic [1:0] mo_mask = 2'b00;
  int         cyc     = 0;

  function automatic logic [1:0] gvec(input bit has, input logic who);
    return has ? (who ? 2'b10 : 2'b01) : 2'b00;
  endfunction

  always @(posedge clk or posedge reset) begin : model
    logic [1:0] g0, nmask, elig;
    logic       to;
    g0 = gvec(mo_has, mo_who);
    to = 1'b0;
    if (reset) begin
      mo_has = 0; mo_cool = 0; mo_run = 0; mo_last = 1'b1; mo_mask = 2'b00;
    end else begin
      cyc++;
      nmask = mo_mask & bus.req;
      if (mo_has) begin
        if (!bus.req[mo_who]) begin
          mo_has = 0; mo_cool = CS_GAP;
        end else begin
          mo_run = bus.m_cs_b[mo_who] ? mo_run + 1 : 0;
          if (MAX_HOLD > 0 && mo_run >= MAX_HOLD) begin
            nmask[mo_who] = 1'b1; to = 1'b1; mo_has = 0; mo_cool = CS_GAP;
          end
        end
      end else if (mo_cool > 0) begin
        mo_cool--;
      end else begin
        elig = bus.req & ~mo_mask;
        if (elig != 2'b00) begin
          mo_has  = 1;
          mo_who  = (elig == 2'b11) ? ~mo_last : (elig == 2'b10);
          mo_last = mo_who;
          mo_run  = 0;
        end
      end
      mo_mask = nmask;
    end
    if (gvec(mo_has, mo_who) != g0 || to) exp_q.push_back('{gvec(mo_has, mo_who), to, cyc});
  end

  // ---------------- monitor ----------------
  logic [1:0] prev_g     = 2'b00;
  int         dut_to_cnt = 0;

  always @(negedge clk) begin : monitor
    logic ecs, esck, emosi, ebusy;
    ev_t  e;
    if (mo_has) begin
      ecs = bus.m_cs_b[mo_who]; esck = bus.m_sck[mo_who]; emosi = bus.m_mosi[mo_who];
    end else begin
      ecs = 1'b1; esck = 1'b0; emosi = 1'b0;
    end
    ebusy = mo_has || (mo_cool > 0);
    chk("spi_cs",   32'(bus.spi_cs),   32'(ecs));
    chk("spi_sck",  32'(bus.spi_sck),  32'(esck));
    chk("spi_mosi", 32'(bus.spi_mosi), 32'(emosi));
    chk("m_miso",   32'(bus.m_miso),   32'({2{bus.spi_miso}}));
    chk("busy",     32'(bus.busy),     32'(ebusy));
    if (bus.timeout_evt) dut_to_cnt++;
    if (bus.grant != prev_g || bus.timeout_evt) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected: grant=%b timeout_evt=%b, expected no event (cyc %0d)",
                 bus.grant, bus.timeout_evt, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_grant",   32'(bus.grant),       32'(e.g));
        chk("sb_timeout", 32'(bus.timeout_evt), 32'(e.to));
        chk("sb_cycle",   32'(cyc),             32'(e.cyc));
      end
    end
    prev_g = bus.grant;
  end

  // ---------------- stimulus ----------------
  int cs_mode [2] = '{0, 0};  // 0 random, 1 held high, 2 held low

  function automatic logic cs_next(input int mode, input logic cur);
    if (mode == 1) return 1'b1;
    if (mode == 2) return 1'b0;
    return ($urandom_range(5) == 0) ? ~cur : cur;
  endfunction

  function automatic logic req_next(input logic r, input logic g);
    if (!r) return ($urandom_range(3) == 0);
    if (g)  return ($urandom_range(11) != 0);
    return ($urandom_range(29) != 0);
  endfunction

  task automatic tick();
    @(posedge clk); #2;
    bus.m_cs_b   = {cs_next(cs_mode[1], bus.m_cs_b[1]), cs_next(cs_mode[0], bus.m_cs_b[0])};
    bus.m_sck    = 2'($urandom);
    bus.m_mosi   = 2'($urandom);
    bus.spi_miso = 1'($urandom);
  endtask

  task automatic wait_grant(input logic [1:0] g, input int budget, input string nm);
    bit seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      tick();
      if (bus.grant == g) seen = 1;
    end
    chk(nm, 32'(seen), 32'd1);
  endtask

  initial begin : stim
    logic [1:0] exp_g;
    int         base;
    reset = 1'b1;
    bus.req = 2'b00; bus.m_cs_b = 2'b11; bus.m_sck = 2'b00; bus.m_mosi = 2'b00; bus.spi_miso = 1'b0;
    repeat (3) tick();
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_cs",    32'(bus.spi_cs), 32'd1);
    chk("rst_tout",  32'(bus.timeout_evt), 32'd0);
    reset = 1'b0;

    // Tie at start: requester 0 wins; requester 1 traffic must not reach pins
    bus.req = 2'b11;
    tick();
    chk("t1_grant", 32'(bus.grant), 32'd1);
    repeat (6) tick();

    // Owner 0 releases while 1 waits: gap then grant 1
    bus.req = 2'b10;
    tick();
    chk("t2_release", 32'(bus.grant), 32'd0);
    wait_grant(2'b10, 10, "t2_regrant");

    // Continuous contention, ~10-cycle ownerships: strict alternation
    cs_mode = '{2, 2};
    bus.req = 2'b11;
    exp_g = 2'b10;
    for (int n = 0; n < 4; n++) begin
      wait_grant(exp_g, 20, "t3_alternate");
      repeat (10) tick();
      bus.req = 2'b11 & ~exp_g;
      tick();
      bus.req = 2'b11;
      exp_g = ~exp_g;
    end

    // Idle owner revoked after MAX_HOLD cycles, stays masked until req drops
    bus.req = 2'b00;
    repeat (8) tick();
    cs_mode = '{0, 1};
    base = dut_to_cnt;
    bus.req = 2'b10;
    wait_grant(2'b10, 5, "t4_grant");
    repeat (12) tick();
    chk("t4_revoked", 32'(bus.grant), 32'd0);
    chk("t4_tout_once", 32'(dut_to_cnt - base), 32'd1);
    repeat (6) tick();
    chk("t4_masked", 32'(bus.grant), 32'd0);
    bus.req = 2'b00;
    cs_mode = '{0, 0};
    tick();
    bus.req = 2'b10;
    wait_grant(2'b10, 5, "t4_regrant");

    // Release on the same edge the hold timer expires: no timeout, no mask
    bus.req = 2'b00;
    repeat (8) tick();
    cs_mode = '{1, 0};
    base = dut_to_cnt;
    bus.req = 2'b01;
    wait_grant(2'b01, 5, "t5_grant");
    repeat (7) tick();
    bus.req = 2'b00;
    tick();
    chk("t5_release", 32'(bus.grant), 32'd0);
    repeat (6) tick();
    chk("t5_no_tout", 32'(dut_to_cnt - base), 32'd0);
    cs_mode = '{2, 0};
    bus.req = 2'b01;
    wait_grant(2'b01, 10, "t5_nomask");

    // Asynchronous reset mid-transfer deselects immediately
    repeat (3) tick();
    chk("t6_cs_low", 32'(bus.spi_cs), 32'd0);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("t6_async_cs",    32'(bus.spi_cs), 32'd1);
    chk("t6_async_grant", 32'(bus.grant),  32'd0);
    repeat (3) tick();
    reset = 1'b0;
    wait_grant(2'b01, 5, "t6_regrant");

    // Randomized traffic
    cs_mode = '{0, 0};
    for (int n = 0; n < 3000; n++) begin
      tick();
      bus.req = {req_next(bus.req[1], bus.grant[1]), req_next(bus.req[0], bus.grant[0])};
    end
    bus.req = 2'b00;
    repeat (12) tick();
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
